// File: rtl/instr_trace_fifo.sv
// Instruction trace FIFO: show-ahead buffer of fetched (warp, instruction, PC) entries for a disassembler.
// Optional build macro TRACE_NOOP_FILTER_EN: when defined, NOOP-class opcodes are filtered before storage.
module instr_trace_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_valid,
    input  logic [7:0]              one_hot_warp_ID_in,
    input  logic [31:0]             instruction_in,
    input  logic [31:0]             PC_in,
    input  logic [7:0]              warp_mask,
    input  logic                    trace_ready,
    output logic                    trace_valid,
    output logic [7:0]              one_hot_warp_ID,
    output logic [31:0]             instruction_out,
    output logic [31:0]             PC,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    bad_warp_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOOP  = 32'h0400_0000;

    typedef struct packed {
        logic [7:0]  warp;
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             warp_one_hot_c;
    logic             warp_enabled_c;
    logic             noop_hit_c;
    logic             push_req_c;
    logic             push_c;
    logic             pop_c;
    logic             drop_c;
    logic             bad_warp_c;
    logic [OCC_W-1:0] count_nxt_c;

    // Qualify the fetch offer and resolve push/pop/drop for this cycle.
    always_comb begin
        warp_one_hot_c = $onehot(one_hot_warp_ID_in);
        warp_enabled_c = warp_one_hot_c && ((one_hot_warp_ID_in & warp_mask) != 8'h00);
`ifdef TRACE_NOOP_FILTER_EN
        noop_hit_c     = (instruction_in[31:26] & 6'b101111) == 6'b000001;
`else
        noop_hit_c     = 1'b0;
`endif
        push_req_c     = fetch_valid && warp_enabled_c && !noop_hit_c;
        pop_c          = !empty && trace_ready;
        push_c         = push_req_c && (!full || pop_c);
        drop_c         = push_req_c && full && !pop_c;
        bad_warp_c     = fetch_valid && !warp_one_hot_c;

        count_nxt_c = count;
        case ({push_c, pop_c})
            2'b10:   count_nxt_c = count + OCC_W'(1);
            2'b01:   count_nxt_c = count - OCC_W'(1);
            default: count_nxt_c = count;
        endcase
    end

    // Pointers, occupancy, flags and error/drop bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            drop_cnt     <= '0;
            bad_warp_err <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt_c;
            empty <= (count_nxt_c == '0);
            full  <= (count_nxt_c == OCC_W'(DEPTH));
            if (drop_c && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
            if (bad_warp_c) bad_warp_err <= 1'b1;
        end
    end

    // Entry storage is not reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= '{warp: one_hot_warp_ID_in, instr: instruction_in, pc: PC_in};
        end
    end

    // Show-ahead head view, forced to NOOP/zero while empty.
    always_comb begin
        trace_valid     = !empty;
        one_hot_warp_ID = 8'h00;
        instruction_out = NOOP;
        PC              = 32'h0;
        if (!empty) begin
            one_hot_warp_ID = mem[rd_ptr].warp;
            instruction_out = mem[rd_ptr].instr;
            PC              = mem[rd_ptr].pc;
        end
    end

endmodule

// File: tb/tb_instr_trace_fifo.sv
// Scoreboard bench for instr_trace_fifo: expected entries queued on accepted pushes, compared on pops.
module tb_instr_trace_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 16;
    localparam logic [31:0] NOOP  = 32'h0400_0000;

    logic              clk;
    logic              rst_n;
    logic              fetch_valid;
    logic [7:0]        one_hot_warp_ID_in;
    logic [31:0]       instruction_in;
    logic [31:0]       PC_in;
    logic [7:0]        warp_mask;
    logic              trace_ready;
    logic              trace_valid;
    logic [7:0]        one_hot_warp_ID;
    logic [31:0]       instruction_out;
    logic [31:0]       PC;
    logic [3:0]        count;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  drop_cnt;
    logic              bad_warp_err;

    instr_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fetch_valid        (fetch_valid),
        .one_hot_warp_ID_in (one_hot_warp_ID_in),
        .instruction_in     (instruction_in),
        .PC_in              (PC_in),
        .warp_mask          (warp_mask),
        .trace_ready        (trace_ready),
        .trace_valid        (trace_valid),
        .one_hot_warp_ID    (one_hot_warp_ID),
        .instruction_out    (instruction_out),
        .PC                 (PC),
        .count              (count),
        .full               (full),
        .empty              (empty),
        .drop_cnt           (drop_cnt),
        .bad_warp_err       (bad_warp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned      total = 0;
    int unsigned      bad   = 0;
    logic [71:0]      sb[$];
    logic [CNT_W-1:0] m_drop = '0;
    logic             m_err  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus from a negedge; update the model on the posedge, check flags after.
    task automatic step(input logic fv, input logic [7:0] id, input logic [31:0] ins,
                        input logic [31:0] pc, input logic [7:0] mask, input logic rdy);
        logic        m_pop, m_push, oh, filt;
        int unsigned pre;
        logic [71:0] h;
        fetch_valid = fv; one_hot_warp_ID_in = id; instruction_in = ins;
        PC_in = pc; warp_mask = mask; trace_ready = rdy;
        #1;
        pre = sb.size();
        check("valid", 64'(trace_valid), 64'(pre != 0));
        if (pre == 0) begin
            check("idle_instr", 64'(instruction_out), 64'(NOOP));
            check("idle_pc", 64'(PC), 64'h0);
            check("idle_warp", 64'(one_hot_warp_ID), 64'h0);
        end
        m_pop = (pre != 0) && rdy;
        if (m_pop) begin
            h = sb[0];
            check("head_warp", 64'(one_hot_warp_ID), 64'(h[71:64]));
            check("head_instr", 64'(instruction_out), 64'(h[63:32]));
            check("head_pc", 64'(PC), 64'(h[31:0]));
        end
        oh   = ($countones(id) == 1);
        filt = 1'b0;
`ifdef TRACE_NOOP_FILTER_EN
        filt = (ins[31] == 1'b0) && (ins[29:26] == 4'b0001);
`endif
        m_push = fv && oh && ((id & mask) != 8'h00) && !filt;
        @(posedge clk);
        if (m_pop) void'(sb.pop_front());
        if (m_push) begin
            if (pre < DEPTH || m_pop) sb.push_back({id, ins, pc});
            else if (m_drop != '1) m_drop = m_drop + CNT_W'(1);
        end
        if (fv && !oh) m_err = 1'b1;
        @(negedge clk);
        check("count", 64'(count), 64'(sb.size()));
        check("full", 64'(full), 64'(sb.size() == DEPTH));
        check("empty", 64'(empty), 64'(sb.size() == 0));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        check("bad_warp_err", 64'(bad_warp_err), 64'(m_err));
    endtask

    // Asynchronous reset pulse starting mid-cycle; outputs checked before any clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_empty", 64'(empty), 64'h1);
        check("rst_full", 64'(full), 64'h0);
        check("rst_count", 64'(count), 64'h0);
        check("rst_valid", 64'(trace_valid), 64'h0);
        check("rst_instr", 64'(instruction_out), 64'(NOOP));
        check("rst_pc", 64'(PC), 64'h0);
        check("rst_warp", 64'(one_hot_warp_ID), 64'h0);
        check("rst_drop", 64'(drop_cnt), 64'h0);
        check("rst_err", 64'(bad_warp_err), 64'h0);
        sb.delete();
        m_drop = '0;
        m_err  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < int'(DEPTH) + 2; i++) step(1'b0, 8'h00, 32'h0, 32'h0, 8'hFF, 1'b1);
        check("drained", 64'(sb.size()), 64'h0);
    endtask

    initial begin
        logic [7:0] rid;
        rst_n = 1'b1; fetch_valid = 1'b0; one_hot_warp_ID_in = 8'h00;
        instruction_in = 32'h0; PC_in = 32'h0; warp_mask = 8'hFF; trace_ready = 1'b0;
        do_reset();

        // Three pushes across warps with a ready consumer.
        step(1'b1, 8'h01, 32'h1111_0001, 32'd0, 8'hFF, 1'b1);
        step(1'b1, 8'h04, 32'h2222_0002, 32'd4, 8'hFF, 1'b1);
        step(1'b1, 8'h80, 32'h3333_0003, 32'd8, 8'hFF, 1'b1);
        drain();

        // Overflow with stalled consumer: 10 offers, 2 dropped.
        for (int i = 0; i < 10; i++)
            step(1'b1, 8'h01 << (i % 8), 32'hA000_0000 + 32'(i), 32'(4 * i), 8'hFF, 1'b0);
        check("ovf_count", 64'(count), 64'd8);
        check("ovf_full", 64'(full), 64'h1);
        check("ovf_drop", 64'(drop_cnt), 64'd2);
        drain();

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++)
            step(1'b1, 8'h02, 32'hB000_0000 + 32'(i), 32'(i), 8'hFF, 1'b0);
        step(1'b1, 8'h40, 32'hBEEF_0000, 32'h100, 8'hFF, 1'b1);
        check("pp_count", 64'(count), 64'd8);
        check("pp_drop", 64'(drop_cnt), 64'd2);
        drain();

        // Single-entry push and pop in the same cycle.
        step(1'b1, 8'h08, 32'hC000_0001, 32'h20, 8'hFF, 1'b0);
        step(1'b1, 8'h10, 32'hC000_0002, 32'h24, 8'hFF, 1'b1);
        check("one_count", 64'(count), 64'd1);
        drain();

        // Bad warp ID and masked-off warp.
        step(1'b1, 8'h03, 32'hD000_0000, 32'h30, 8'hFF, 1'b1);
        check("bad_err", 64'(bad_warp_err), 64'h1);
        step(1'b1, 8'h01, 32'hD000_0001, 32'h34, 8'hFE, 1'b1);
        check("mask_count", 64'(count), 64'h0);
        step(1'b1, 8'h00, 32'hD000_0002, 32'h38, 8'hFF, 1'b1);
        drain();
        check("bad_sticky", 64'(bad_warp_err), 64'h1);

        // NOOP opcode storage depends on the filter build option.
        step(1'b1, 8'h20, NOOP, 32'h40, 8'hFF, 1'b0);
        step(1'b1, 8'h20, 32'h4400_0000, 32'h44, 8'hFF, 1'b0);
        step(1'b1, 8'h20, 32'h0800_0000, 32'h48, 8'hFF, 1'b0);
`ifdef TRACE_NOOP_FILTER_EN
        check("noop_count", 64'(count), 64'd1);
`else
        check("noop_count", 64'(count), 64'd3);
`endif
        drain();

        // Reset with five entries held and a push being offered.
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'h04, 32'hE000_0000 + 32'(i), 32'(i), 8'hFF, 1'b0);
        check("pre_rst_count", 64'(count), 64'd5);
        fetch_valid = 1'b1; one_hot_warp_ID_in = 8'h01; trace_ready = 1'b1;
        do_reset();
        step(1'b0, 8'h00, 32'h0, 32'h0, 8'hFF, 1'b1);

        // Random mixed traffic.
        for (int i = 0; i < 300; i++) begin
            rid = ($urandom_range(0, 9) < 8) ? (8'h01 << $urandom_range(0, 7)) : 8'($urandom);
            step(1'($urandom_range(0, 3) != 0), rid, $urandom, $urandom,
                 8'($urandom) | 8'h0F, 1'($urandom_range(0, 2) != 0));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_trace_fifo.md
INSTR_TRACE_FIFO -- requirements
Module: instr_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count (power of two, 2..64).
REQ-002 SHALL have parameter CNT_W, default 16, width of the drop counter.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port fetch_valid  in  1  fetch stage presents an instruction this cycle.
REQ-006 SHALL have port one_hot_warp_ID_in  in  8  one-hot warp of the fetched instruction.
REQ-007 SHALL have port instruction_in  in  32  fetched instruction word.
REQ-008 SHALL have port PC_in  in  32  PC of the fetched instruction.
REQ-009 SHALL have port warp_mask  in  8  per-warp trace enable; bit i enables warp i.
REQ-010 SHALL have port trace_ready  in  1  downstream disassembler accepts the head entry.
REQ-011 SHALL have port trace_valid  out  1  head entry valid.
REQ-012 SHALL have port one_hot_warp_ID  out  8  head entry warp, one-hot.
REQ-013 SHALL have port instruction_out  out  32  head entry instruction.
REQ-014 SHALL have port PC  out  32  head entry PC.
REQ-015 SHALL have port count  out  $clog2(DEPTH)+1  current occupancy.
REQ-016 SHALL have port full, empty  out  1 each  occupancy == DEPTH / == 0.
REQ-017 SHALL have port drop_cnt  out  CNT_W  entries lost to overflow, saturating.
REQ-018 SHALL have port bad_warp_err  out  1  sticky: a non-one-hot warp ID was offered.

Function
REQ-019 Push SHALL occur when fetch_valid=1, one_hot_warp_ID_in has exactly one bit set, that bit's warp_mask bit=1, and (not full or pop this cycle).
REQ-020 Pop SHALL occur when trace_valid=1 and trace_ready=1; head advances on that edge.
REQ-021 Output SHALL be show-ahead: head fields are driven from storage; an entry pushed at edge N is visible with trace_valid=1 after edge N (one-cycle latency).
REQ-022 When empty, trace_valid SHALL be 0, instruction_out SHALL be 32'h0400_0000 (NOOP), PC and one_hot_warp_ID SHALL be 0.
REQ-023 Simultaneous push and pop SHALL leave count unchanged, also when full or when count==1.
REQ-024 Push attempt while full without pop SHALL be dropped; drop_cnt SHALL increment by 1, saturating at all ones.
REQ-025 Non-one-hot warp ID with fetch_valid=1 SHALL not be stored and SHALL set bad_warp_err until reset; drop_cnt unaffected.
REQ-026 Masked-off warp SHALL be silently ignored (no drop, no error).
REQ-027 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL distinguish full from empty.
REQ-028 Entries SHALL be delivered in push order; no reordering across warps.

Reset
REQ-029 rst_n low SHALL immediately clear pointers, count, drop_cnt, bad_warp_err; empty=1, full=0, trace_valid=0.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; no partial pop/push completes on that edge.
REQ-031 Storage contents need not be reset; outputs obey REQ-022 while empty.

Configuration
REQ-032 Macro TRACE_NOOP_FILTER_EN defined: instructions with opcode [31:26] matching 0?0001 SHALL not be pushed and SHALL not count as drops.
REQ-033 Macro undefined: NOOPs SHALL be stored like any other instruction.

Verification
REQ-034 Reset, then push 3 entries (warps 8'h01,8'h04,8'h80; PC 0,4,8), trace_ready=1 -> same 3 entries out in order, first trace_valid one cycle after first push.
REQ-035 DEPTH=8, trace_ready=0, 10 valid pushes -> full=1, count=8, drop_cnt=2; then drain -> first 8 entries only.
REQ-036 Full FIFO, push and pop in same cycle -> count stays 8, drop_cnt unchanged, new entry delivered last.
REQ-037 Offer one_hot_warp_ID_in=8'h03 -> not stored, bad_warp_err=1 until rst_n low; warp_mask=8'hFE with warp 8'h01 -> ignored, no flags.
REQ-038 Push 32'h0400_0000 -> stored and output when TRACE_NOOP_FILTER_EN undefined; count stays 0 when defined.
REQ-039 Assert rst_n low with count=5 -> empty=1, count=0, instruction_out=32'h0400_0000 without waiting for clk.
